// File: rtl/cla_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead adder.
package cla_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Counter width for a given slice count; never below one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cla4.sv
// Combinational 4-bit carry-lookahead slice with carry-in.
module cla4
  import cla_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                cin_i,
  output logic [NIBBLE_W-1:0] s_o,
  output logic                cout_o
);

  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W:0]   c;

  assign g = a_i & b_i;
  assign p = a_i | b_i;

  assign c[0] = cin_i;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
                (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign s_o    = a_i ^ b_i ^ c[NIBBLE_W-1:0];
  assign cout_o = c[NIBBLE_W];

endmodule

// File: rtl/cla_serial_adder.sv
// Wide adder that streams operands one nibble per cycle through a cla4 slice.
// Optional subtraction (a - b) is enabled by defining CLA_SUBTRACT_EN.
module cla_serial_adder
  import cla_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [NIBBLE_W*NIBBLES-1:0] a_i,
  input  logic [NIBBLE_W*NIBBLES-1:0] b_i,
`ifdef CLA_SUBTRACT_EN
  input  logic                        sub_i,
`endif
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [NIBBLE_W*NIBBLES-1:0] sum_o,
  output logic                        carry_out_o,
  output logic                        busy_o
);

  localparam int unsigned W    = NIBBLE_W * NIBBLES;
  localparam int unsigned CntW = cnt_w(NIBBLES);

  state_t            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [W-1:0]      sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;

  logic [W-1:0]          b_in;
  logic                  cin_in;
  logic [NIBBLE_W-1:0]   slice_s;
  logic                  slice_c;
  logic                  cnt_last;

  cla4 u_cla4 (
    .a_i    (a_q[cnt_q*NIBBLE_W +: NIBBLE_W]),
    .b_i    (b_q[cnt_q*NIBBLE_W +: NIBBLE_W]),
    .cin_i  (carry_q),
    .s_o    (slice_s),
    .cout_o (slice_c)
  );

  assign cnt_last = (cnt_q == CntW'(NIBBLES - 1));

  // Subtraction is a + ~b + 1, so only the operand and seed carry change.
  always_comb begin
    b_in   = b_i;
    cin_in = 1'b0;
`ifdef CLA_SUBTRACT_EN
    if (sub_i) begin
      b_in   = ~b_i;
      cin_in = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          a_d     = a_i;
          b_d     = b_in;
          carry_d = cin_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[cnt_q*NIBBLE_W +: NIBBLE_W] = slice_s;
        carry_d = slice_c;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_last) begin
          cout_d  = slice_c;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign sum_o       = sum_q;
  assign carry_out_o = cout_q;

endmodule
